block_router: RTL and testbench

BLOCK_ROUTER -- requirements
Module: block_router

---
 rtl/block_router.sv | 236 +++++++++++++++++++++++
 tb/tb_block_router.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_router.sv
// block_router
//   Sorts blocks arriving from the receive shifter into three kinds:
//   plaintext (forwarded to the buffer through a valid/ready hold stage),
//   key material (written to a key register slot), and header commands
//   (load-key / select-slot / error). A header is any block whose bits
//   [BLOCK_W-1:8] match MAGIC; its low byte is {op[1:0], idx[5:0]}.
//
//   Header ops:
//     op=00, idx<KEY_SLOTS : next accepted block is stored verbatim as key[idx]
//     op=01, idx<KEY_SLOTS : active_slot <= idx
//     anything else        : one-cycle cmd_err pulse
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-low reset
//   block        in   [BLOCK_W] incoming block
//   write_en     in   block valid; ignored (dropped) while in_ready=0
//   in_ready     out  combinational; high in IDLE and WAIT_KEY
//   pt_block     out  [BLOCK_W] plaintext block to the buffer
//   pt_valid     out  pt_block valid, held until pt_ready is sampled high
//   pt_ready     in   downstream accepts pt_block
//   key_block    out  [BLOCK_W] key value
//   key_slot     out  [SLOT_W] destination slot of key_block
//   key_write    out  one-cycle key-register write strobe
//   active_slot  out  [SLOT_W] slot selected for encryption
//   cmd_err      out  one-cycle error pulse
//
// Optional feature
//   KEYSEL_TIMEOUT_EN : when defined, WAIT_KEY gives up after TIMEOUT cycles
//   without a key (cmd_err pulse, back to IDLE). When undefined, WAIT_KEY
//   waits indefinitely and TIMEOUT has no effect.
//
// State     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a new block
// CHECK     | one cycle decoding the captured block (header or plaintext)
// WAIT_KEY  | load-key header seen; next accepted block is the key
// HOLD_PT   | plaintext presented, waiting for pt_ready

module block_router #(
    parameter int                 BLOCK_W   = 128,
    parameter int                 KEY_SLOTS = 4,
    parameter logic [BLOCK_W-1:0] MAGIC     = BLOCK_W'(128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBE00),
    parameter int                 TIMEOUT   = 1024,
    localparam int                SLOT_W    = $clog2(KEY_SLOTS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BLOCK_W-1:0] block,
    input  logic               write_en,
    output logic               in_ready,
    output logic [BLOCK_W-1:0] pt_block,
    output logic               pt_valid,
    input  logic               pt_ready,
    output logic [BLOCK_W-1:0] key_block,
    output logic [SLOT_W-1:0]  key_slot,
    output logic               key_write,
    output logic [SLOT_W-1:0]  active_slot,
    output logic               cmd_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        WAIT_KEY = 2'd2,
        HOLD_PT  = 2'd3
    } state_t;

    // idx is 6 bits wide; compare in 7 bits so KEY_SLOTS=64 still fits.
    localparam logic [6:0] SLOT_LIM = 7'(KEY_SLOTS);

    if (BLOCK_W < 16 || (BLOCK_W % 8) != 0) begin : g_bad_block_w
        $error("block_router: BLOCK_W must be a multiple of 8 and at least 16");
    end
    if (KEY_SLOTS < 2 || KEY_SLOTS > 64) begin : g_bad_key_slots
        $error("block_router: KEY_SLOTS must be in 2..64");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("block_router: TIMEOUT must be at least 1");
    end

    state_t             state;
    state_t             state_nx;
    logic [BLOCK_W-1:0] block_in;
    logic [BLOCK_W-1:0] block_in_nx;
    logic [SLOT_W-1:0]  pend_slot;
    logic [SLOT_W-1:0]  pend_slot_nx;
    logic [BLOCK_W-1:0] pt_block_nx;
    logic               pt_valid_nx;
    logic [BLOCK_W-1:0] key_block_nx;
    logic [SLOT_W-1:0]  key_slot_nx;
    logic               key_write_nx;
    logic [SLOT_W-1:0]  active_slot_nx;
    logic               cmd_err_nx;

    logic               is_header;
    logic [1:0]         op;
    logic [5:0]         idx;
    logic               idx_ok;

    assign is_header = (block_in[BLOCK_W-1:8] == MAGIC[BLOCK_W-1:8]);
    assign op        = block_in[7:6];
    assign idx       = block_in[5:0];
    assign idx_ok    = ({1'b0, idx} < SLOT_LIM);

    assign in_ready  = (state == IDLE) || (state == WAIT_KEY);

`ifdef KEYSEL_TIMEOUT_EN
    localparam int               CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] to_cnt;
    logic [CNT_W-1:0] to_cnt_nx;
    logic             to_hit;

    assign to_hit = (to_cnt == TO_LAST);
`endif

    always_comb begin
        state_nx       = state;
        block_in_nx    = block_in;
        pend_slot_nx   = pend_slot;
        pt_block_nx    = pt_block;
        pt_valid_nx    = pt_valid;
        key_block_nx   = key_block;
        key_slot_nx    = key_slot;
        key_write_nx   = 1'b0;
        active_slot_nx = active_slot;
        cmd_err_nx     = 1'b0;
`ifdef KEYSEL_TIMEOUT_EN
        to_cnt_nx      = to_cnt;
`endif

        unique case (state)
            IDLE: begin
                if (write_en) begin
                    block_in_nx = block;
                    state_nx    = CHECK;
                end
            end

            CHECK: begin
                if (is_header) begin
                    if (op == 2'b00 && idx_ok) begin
                        pend_slot_nx = idx[SLOT_W-1:0];
                        state_nx     = WAIT_KEY;
`ifdef KEYSEL_TIMEOUT_EN
                        to_cnt_nx    = '0;
`endif
                    end else if (op == 2'b01 && idx_ok) begin
                        active_slot_nx = idx[SLOT_W-1:0];
                        state_nx       = IDLE;
                    end else begin
                        cmd_err_nx = 1'b1;
                        state_nx   = IDLE;
                    end
                end else begin
                    pt_block_nx = block_in;
                    pt_valid_nx = 1'b1;
                    state_nx    = HOLD_PT;
                end
            end

            WAIT_KEY: begin
                // The key is taken verbatim; it is never decoded as a header.
                // A key arriving on the terminal-count cycle beats the timeout.
                if (write_en) begin
                    key_block_nx = block;
                    key_slot_nx  = pend_slot;
                    key_write_nx = 1'b1;
                    state_nx     = IDLE;
                end
`ifdef KEYSEL_TIMEOUT_EN
                else if (to_hit) begin
                    cmd_err_nx = 1'b1;
                    state_nx   = IDLE;
                end else begin
                    to_cnt_nx = to_cnt + 1'b1;
                end
`else
                // No timeout: stay here until a key arrives.
`endif
            end

            HOLD_PT: begin
                if (pt_ready) begin
                    pt_valid_nx = 1'b0;
                    state_nx    = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            block_in    <= '0;
            pend_slot   <= '0;
            pt_block    <= '0;
            pt_valid    <= 1'b0;
            key_block   <= '0;
            key_slot    <= '0;
            key_write   <= 1'b0;
            active_slot <= '0;
            cmd_err     <= 1'b0;
`ifdef KEYSEL_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            block_in    <= block_in_nx;
            pend_slot   <= pend_slot_nx;
            pt_block    <= pt_block_nx;
            pt_valid    <= pt_valid_nx;
            key_block   <= key_block_nx;
            key_slot    <= key_slot_nx;
            key_write   <= key_write_nx;
            active_slot <= active_slot_nx;
            cmd_err     <= cmd_err_nx;
`ifdef KEYSEL_TIMEOUT_EN
            to_cnt      <= to_cnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_block_router.sv
// tb_block_router
//   Self-checking bench for block_router (BLOCK_W=128, KEY_SLOTS=4,
//   TIMEOUT=16). Directed cases cover reset, latency, backpressure, key
//   loading, slot select, errors, the optional timeout and reset in
//   WAIT_KEY; a randomized phase is then scored against a transaction-level
//   model (expected plaintext / key-write queues, error count, active slot).

module tb_block_router;

    localparam int BW = 128;
    localparam int NS = 4;
    localparam int SW = 2;
    localparam int TO = 16;
    localparam logic [119:0] MAGIC_HI = 120'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBE;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [BW-1:0] block = '0;
    logic          write_en = 1'b0;
    logic          in_ready;
    logic [BW-1:0] pt_block;
    logic          pt_valid;
    logic          pt_ready = 1'b0;
    logic [BW-1:0] key_block;
    logic [SW-1:0] key_slot;
    logic          key_write;
    logic [SW-1:0] active_slot;
    logic          cmd_err;

    block_router #(
        .BLOCK_W   (BW),
        .KEY_SLOTS (NS),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .block       (block),
        .write_en    (write_en),
        .in_ready    (in_ready),
        .pt_block    (pt_block),
        .pt_valid    (pt_valid),
        .pt_ready    (pt_ready),
        .key_block   (key_block),
        .key_slot    (key_slot),
        .key_write   (key_write),
        .active_slot (active_slot),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [SW-1:0] slot;
        logic [BW-1:0] blk;
    } key_ev_t;

    // Observed events, sampled on the falling edge.
    key_ev_t       obs_key[$];
    logic [BW-1:0] obs_pt[$];
    int            kw_cnt   = 0;
    int            err_cnt  = 0;
    int            xfer_cnt = 0;
    logic          prev_kw  = 1'b0;
    logic          prev_err = 1'b0;

    initial begin
        key_ev_t ev;
        forever begin
            @(negedge clk);
            if (key_write === 1'b1 || cmd_err === 1'b1) begin
                check("kw_err_overlap", BW'(key_write & cmd_err), BW'(0));
                check("kw_repeat", BW'(prev_kw & key_write), BW'(0));
                check("err_repeat", BW'(prev_err & cmd_err), BW'(0));
            end
            prev_kw  = (key_write === 1'b1);
            prev_err = (cmd_err === 1'b1);
            if (key_write === 1'b1) begin
                ev.slot = key_slot;
                ev.blk  = key_block;
                obs_key.push_back(ev);
                kw_cnt++;
            end
            if (cmd_err === 1'b1) err_cnt++;
            if (pt_valid === 1'b1 && pt_ready === 1'b1) begin
                obs_pt.push_back(pt_block);
                xfer_cnt++;
            end
        end
    end

    // Random downstream backpressure, changed just after the rising edge.
    logic pt_ready_rand = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pt_ready_rand) pt_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [BW-1:0] rnd_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [BW-1:0] hdr(input logic [7:0] lo);
        return {MAGIC_HI, lo};
    endfunction

    logic drop_en = 1'b0;

    // Waits for in_ready (bounded), then presents b for one accepting edge.
    // Returns 1 time unit after the accepting edge.
    task automatic send(input logic [BW-1:0] b);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            if (drop_en && $urandom_range(0, 3) == 0) begin
                block    = rnd_blk();
                write_en = 1'b1;
            end
            @(posedge clk);
            #1 write_en = 1'b0;
            @(negedge clk);
            waited++;
        end
        check("in_ready_wait", BW'(in_ready), BW'(1));
        block    = b;
        write_en = 1'b1;
        @(posedge clk);
        #1 write_en = 1'b0;
    endtask

    logic [BW-1:0] pt, pt2, key, key2, junk;
    int            k0, e0, x0, seen, exp_err;
    logic [SW-1:0] exp_active, w_slot;
    logic          waiting;
    logic [BW-1:0] exp_pt[$];
    key_ev_t       exp_key[$];

    initial begin
        key_ev_t       ev;
        logic [BW-1:0] b;
        logic [1:0]    op;
        logic [5:0]    idx;

        pt   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        key  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        pt2  = 128'hCAFEF00D_00000001_00000002_00000003;
        key2 = 128'h55AA55AA_0F0F0F0F_F0F0F0F0_12345678;
        junk = 128'h11111111_22222222_33333333_44444444;

        // Reset
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        pt_ready = 1'b1;
        @(negedge clk);
        check("rst_in_ready", BW'(in_ready), BW'(1));
        check("rst_pt_valid", BW'(pt_valid), BW'(0));
        check("rst_pt_block", pt_block, BW'(0));
        check("rst_key_write", BW'(key_write), BW'(0));
        check("rst_key_block", key_block, BW'(0));
        check("rst_key_slot", BW'(key_slot), BW'(0));
        check("rst_active_slot", BW'(active_slot), BW'(0));
        check("rst_cmd_err", BW'(cmd_err), BW'(0));

        // Plaintext, pt_ready=1: valid for exactly one cycle, two cycles after accept
        send(pt);
        @(negedge clk);
        check("pt_lat_check_cycle", BW'(pt_valid), BW'(0));
        @(negedge clk);
        check("pt_lat_valid", BW'(pt_valid), BW'(1));
        check("pt_data", pt_block, pt);
        @(negedge clk);
        check("pt_one_cycle", BW'(pt_valid), BW'(0));
        check("pt_back_idle", BW'(in_ready), BW'(1));

        // Plaintext held 5 cycles by backpressure; write during hold is dropped
        @(posedge clk);
        #1 pt_ready = 1'b0;
        x0 = xfer_cnt;
        send(pt);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", BW'(pt_valid), BW'(1));
            check("hold_in_ready", BW'(in_ready), BW'(0));
            check("hold_data", pt_block, pt);
            if (i == 2) begin
                block    = junk;
                write_en = 1'b1;
            end
            @(posedge clk);
            #1 write_en = 1'b0;
            if (i == 4) pt_ready = 1'b1;
            @(negedge clk);
        end
        check("hold_valid_at_ready", BW'(pt_valid), BW'(1));
        @(negedge clk);
        check("hold_released", BW'(pt_valid), BW'(0));
        repeat (4) @(negedge clk);
        check("hold_single_xfer", BW'(xfer_cnt - x0), BW'(1));
        check("hold_drop_no_pt", BW'(pt_valid), BW'(0));

        // Load key into slot 2; then a header pattern sent as key is stored verbatim
        k0 = kw_cnt;
        send(hdr(8'h02));
        @(negedge clk);
        @(negedge clk);
        check("hdr_wait_ready", BW'(in_ready), BW'(1));
        check("hdr_no_kw", BW'(key_write), BW'(0));
        send(key);
        @(negedge clk);
        check("key_write", BW'(key_write), BW'(1));
        check("key_slot", BW'(key_slot), BW'(2));
        check("key_block", key_block, key);
        @(negedge clk);
        check("key_write_one_cycle", BW'(key_write), BW'(0));
        send(hdr(8'h03));
        send(hdr(8'h41));
        @(negedge clk);
        check("hdr_as_key_write", BW'(key_write), BW'(1));
        check("hdr_as_key_slot", BW'(key_slot), BW'(3));
        check("hdr_as_key_block", key_block, hdr(8'h41));
        repeat (2) @(negedge clk);
        check("hdr_as_key_not_decoded", BW'(active_slot), BW'(0));
        check("key_write_total", BW'(kw_cnt - k0), BW'(2));

        // Slot select and error headers
        k0 = kw_cnt;
        e0 = err_cnt;
        send(hdr(8'h41));
        @(negedge clk);
        @(negedge clk);
        check("sel_active", BW'(active_slot), BW'(1));
        repeat (2) @(negedge clk);
        check("sel_no_err", BW'(err_cnt - e0), BW'(0));
        check("sel_no_kw", BW'(kw_cnt - k0), BW'(0));
        send(hdr(8'h04));
        @(negedge clk);
        check("idx_err_not_early", BW'(cmd_err), BW'(0));
        @(negedge clk);
        check("idx_err_pulse", BW'(cmd_err), BW'(1));
        @(negedge clk);
        check("idx_err_one_cycle", BW'(cmd_err), BW'(0));
        send(hdr(8'h80));
        @(negedge clk);
        @(negedge clk);
        check("op2_err_pulse", BW'(cmd_err), BW'(1));
        send(hdr(8'hC1));
        @(negedge clk);
        @(negedge clk);
        check("op3_err_pulse", BW'(cmd_err), BW'(1));
        repeat (2) @(negedge clk);
        check("err_total", BW'(err_cnt - e0), BW'(3));
        check("err_no_kw", BW'(kw_cnt - k0), BW'(0));
        check("err_keeps_active", BW'(active_slot), BW'(1));

`ifdef KEYSEL_TIMEOUT_EN
        // Timeout: WAIT_KEY entered on the edge after accept; error 16 cycles later
        e0 = err_cnt;
        k0 = kw_cnt;
        send(hdr(8'h00));
        seen = 0;
        for (int j = 1; j <= 40 && seen == 0; j++) begin
            @(negedge clk);
            if (cmd_err) seen = j;
        end
        check("to_err_cycle", BW'(seen), BW'(18));
        @(negedge clk);
        check("to_err_one_cycle", BW'(cmd_err), BW'(0));
        check("to_back_idle", BW'(in_ready), BW'(1));
        check("to_no_kw", BW'(kw_cnt - k0), BW'(0));
        send(pt2);
        @(negedge clk);
        @(negedge clk);
        check("to_next_is_pt", BW'(pt_valid), BW'(1));
        check("to_next_pt_data", pt_block, pt2);
        @(negedge clk);
        // Key arriving on the terminal-count cycle wins
        e0 = err_cnt;
        send(hdr(8'h01));
        repeat (17) @(negedge clk);
        check("to_term_still_waiting", BW'(in_ready), BW'(1));
        block    = key2;
        write_en = 1'b1;
        @(posedge clk);
        #1 write_en = 1'b0;
        @(negedge clk);
        check("to_term_kw", BW'(key_write), BW'(1));
        check("to_term_key", key_block, key2);
        check("to_term_slot", BW'(key_slot), BW'(1));
        check("to_term_no_err", BW'(cmd_err), BW'(0));
        repeat (3) @(negedge clk);
        check("to_term_err_total", BW'(err_cnt - e0), BW'(0));
`else
        // No timeout build: WAIT_KEY waits indefinitely
        e0 = err_cnt;
        send(hdr(8'h00));
        repeat (60) @(negedge clk);
        check("wait_no_err", BW'(err_cnt - e0), BW'(0));
        check("wait_still_ready", BW'(in_ready), BW'(1));
        send(key2);
        @(negedge clk);
        check("wait_late_kw", BW'(key_write), BW'(1));
        check("wait_late_slot", BW'(key_slot), BW'(0));
        check("wait_late_key", key_block, key2);
`endif

        // Reset while in WAIT_KEY, with a key presented on the same edge
        send(hdr(8'h42));
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_active", BW'(active_slot), BW'(2));
        k0 = kw_cnt;
        send(hdr(8'h03));
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_waiting", BW'(in_ready), BW'(1));
        reset    = 1'b0;
        block    = key;
        write_en = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        write_en = 1'b0;
        @(negedge clk);
        check("wk_rst_kw", BW'(key_write), BW'(0));
        check("wk_rst_key_block", key_block, BW'(0));
        check("wk_rst_key_slot", BW'(key_slot), BW'(0));
        check("wk_rst_active", BW'(active_slot), BW'(0));
        check("wk_rst_pt_block", pt_block, BW'(0));
        check("wk_rst_pt_valid", BW'(pt_valid), BW'(0));
        check("wk_rst_cmd_err", BW'(cmd_err), BW'(0));
        check("wk_rst_in_ready", BW'(in_ready), BW'(1));
        send(key);
        @(negedge clk);
        @(negedge clk);
        check("wk_rst_next_pt", BW'(pt_valid), BW'(1));
        check("wk_rst_next_pt_data", pt_block, key);
        @(negedge clk);
        check("wk_rst_no_kw", BW'(kw_cnt - k0), BW'(0));

        // Randomized traffic against the transaction-level model
        @(posedge clk);
        #1;
        obs_pt.delete();
        obs_key.delete();
        e0         = err_cnt;
        exp_err    = 0;
        exp_active = '0;
        waiting    = 1'b0;
        w_slot     = '0;
        pt_ready_rand = 1'b1;
        drop_en       = 1'b1;
        for (int t = 0; t < 300; t++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            if (waiting) begin
                b = ($urandom_range(0, 3) == 0) ? hdr(8'($urandom_range(0, 255))) : rnd_blk();
                ev.slot = w_slot;
                ev.blk  = b;
                exp_key.push_back(ev);
                waiting = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                b = rnd_blk();
                if (b[BW-1:8] == MAGIC_HI) b[BW-1] = ~b[BW-1];
                exp_pt.push_back(b);
            end else begin
                op  = 2'($urandom_range(0, 3));
                idx = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 5));
                b   = hdr({op, idx});
                if (op == 2'd0 && idx < NS) begin
                    waiting = 1'b1;
                    w_slot  = idx[SW-1:0];
                end else if (op == 2'd1 && idx < NS) begin
                    exp_active = idx[SW-1:0];
                end else begin
                    exp_err++;
                end
            end
            send(b);
        end
        if (waiting) begin
            b       = rnd_blk();
            ev.slot = w_slot;
            ev.blk  = b;
            exp_key.push_back(ev);
            send(b);
        end
        drop_en = 1'b0;
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            if (!pt_valid && in_ready) break;
        end
        @(posedge clk);
        #1 pt_ready_rand = 1'b0;
        repeat (3) @(negedge clk);
        check("rnd_drained", BW'(pt_valid), BW'(0));
        check("rnd_pt_count", BW'(obs_pt.size()), BW'(exp_pt.size()));
        for (int i = 0; i < exp_pt.size() && i < obs_pt.size(); i++)
            check("rnd_pt_data", obs_pt[i], exp_pt[i]);
        check("rnd_key_count", BW'(obs_key.size()), BW'(exp_key.size()));
        for (int i = 0; i < exp_key.size() && i < obs_key.size(); i++) begin
            check("rnd_key_slot", BW'(obs_key[i].slot), BW'(exp_key[i].slot));
            check("rnd_key_data", obs_key[i].blk, exp_key[i].blk);
        end
        check("rnd_err_count", BW'(err_cnt - e0), BW'(exp_err));
        check("rnd_active_slot", BW'(active_slot), BW'(exp_active));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
